// File: rtl/aes_sbox_pipe_pkg.sv
// Shared AES S-box constants and lookup helpers.
//   AES_SBOX     : FIPS-197 forward substitution table.
//   AES_INV_SBOX : exact inverse of AES_SBOX.
//   sbox_fwd(b)  : forward lookup.
//   sbox_inv(b)  : inverse lookup.
package aes_sbox_pipe_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return AES_SBOX[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return AES_INV_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_pipe_lane.sv
// One byte lane of the S-box: purely combinational lookup.
//   data  : byte to substitute
//   inv   : 1 selects the inverse table (only when INV_EN=1)
//   sub_c : substituted byte
module aes_sbox_pipe_lane
    import aes_sbox_pipe_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [BYTE_W-1:0] data,
    input  logic              inv,
    output logic [BYTE_W-1:0] sub_c
);

    generate
        if (INV_EN) begin : g_fwd_inv
            assign sub_c = inv ? sbox_inv(data) : sbox_fwd(data);
        end else begin : g_fwd_only
            // Inverse table is not built; the mode bit is intentionally dropped.
            logic unused_inv;
            assign unused_inv = inv;
            assign sub_c      = sbox_fwd(data);
        end
    endgenerate

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES SubBytes / InvSubBytes engine with an elastic
// valid/ready register chain.
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : input handshake (in_ready is combinational on out_ready)
//   in_data, in_inv       : LANES bytes and per-beat mode
//   out_valid/out_ready   : output handshake
//   out_data, out_inv     : substituted bytes and the beat's mode bit
//   busy                  : any stage holds a beat
module aes_sbox_pipe
    import aes_sbox_pipe_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned PIPE_STAGES = 2,
    parameter bit          INV_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*LANES-1:0]   in_data,
    input  logic                      in_inv,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*LANES-1:0]   out_data,
    output logic                      out_inv,
    output logic                      busy
);

    localparam int unsigned DW   = BYTE_W * LANES;
    localparam int unsigned LAST = PIPE_STAGES - 1;

    logic                   inv_eff;
    logic [DW-1:0]          sub_data;
    logic [PIPE_STAGES-1:0] v;
    logic [PIPE_STAGES-1:0] rdy;
    logic [DW-1:0]          d [PIPE_STAGES];
    logic                   m [PIPE_STAGES];

    assign inv_eff = INV_EN ? in_inv : 1'b0;

    // Combinational substitution feeding stage 0.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_pipe_lane #(.INV_EN(INV_EN)) u_lane (
            .data  (in_data[BYTE_W*i +: BYTE_W]),
            .inv   (inv_eff),
            .sub_c (sub_data[BYTE_W*i +: BYTE_W])
        );
    end

    // Ready ripples backwards: a stage can load if empty or its successor moves.
    always_comb begin
        rdy = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            if (k == int'(LAST)) rdy[k] = !v[k] || out_ready;
            else                 rdy[k] = !v[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic          up_valid;
        logic [DW-1:0] up_data;
        logic          up_inv;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = sub_data;
            assign up_inv   = inv_eff;
        end else begin : g_body
            assign up_valid = v[k-1];
            assign up_data  = d[k-1];
            assign up_inv   = m[k-1];
        end

        // Payload only moves with a real beat so a stalled or empty stage holds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v[k] <= 1'b0;
                d[k] <= '0;
                m[k] <= 1'b0;
            end else if (rdy[k]) begin
                v[k] <= up_valid;
                if (up_valid) begin
                    d[k] <= up_data;
                    m[k] <= up_inv;
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[LAST];
    assign out_data  = d[LAST];
    assign out_inv   = m[LAST];
    assign busy      = |v;

endmodule
